// File: rtl/oc8051_etr_bank_if.sv
// SFR bus and ecall lookup handshake of the ecall target register bank.
interface oc8051_etr_bank_if #(
  parameter int ADDR_W = 16
) ();
  logic              wr;
  logic              wr_bit;
  logic [7:0]        wr_addr;
  logic [7:0]        data_in;
  logic [7:0]        rd_addr;
  logic [7:0]        data_out;
  logic              ecall_req;
  logic [3:0]        ecall_idx;
  logic              ecall_ack;
  logic [ADDR_W-1:0] ecall_target;
  logic              ecall_fault;
  logic              locked;

  // Core side: drives SFR accesses and lookup requests.
  modport master (
    output wr, wr_bit, wr_addr, data_in, rd_addr, ecall_req, ecall_idx,
    input  data_out, ecall_ack, ecall_target, ecall_fault, locked
  );

  // Register bank side.
  modport slave (
    input  wr, wr_bit, wr_addr, data_in, rd_addr, ecall_req, ecall_idx,
    output data_out, ecall_ack, ecall_target, ecall_fault, locked
  );
endinterface

// File: rtl/oc8051_etr_bank.sv
// Multi-entry ecall target register bank.
// Firmware stages a target through LO/HI, picks an entry with SEL and commits or
// invalidates it through CTL. A sticky lock freezes the table contents. The decode
// logic fetches targets over a req/ack handshake served by a three-state FSM.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for ecall_req; captures ecall_idx when it is seen
//  ST_LOOKUP | target/fault registered from the table at the next edge
//  ST_RESP   | ecall_ack high for this single cycle, then back to idle
module oc8051_etr_bank #(
  parameter int         N_ENTRIES = 4,
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] SFR_SEL   = 8'hF9,
  parameter logic [7:0] SFR_LO    = 8'hFA,
  parameter logic [7:0] SFR_HI    = 8'hFB,
  parameter logic [7:0] SFR_CTL   = 8'hFC
) (
  input logic               clk,
  input logic               rst,
  oc8051_etr_bank_if.slave  bus
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int HI_W  = ADDR_W - 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [IDX_W-1:0]     r_sel;
  logic [ADDR_W-1:0]    r_stage;
  logic [ADDR_W-1:0]    r_entry [N_ENTRIES];
  logic [N_ENTRIES-1:0] r_valid;
  logic                 r_lock;
  logic [1:0]           r_state;
  logic [3:0]           r_idx;
  logic [ADDR_W-1:0]    r_target;
  logic                 r_fault;

  logic                 w_wr_en;
  logic                 w_wr_sel;
  logic                 w_wr_lo;
  logic                 w_wr_hi;
  logic                 w_wr_ctl;
  logic                 w_sel_ok;
  logic                 w_sel_valid;
  logic                 w_idx_ok;
  logic [IDX_W-1:0]     w_idx_trunc;
  logic                 w_lk_fault;
  logic [ADDR_W-1:0]    w_lk_target;
  logic                 w_tbl_upd;
  logic [7:0]           w_data_out;

  // Bit-addressed writes never touch this block.
  assign w_wr_en  = bus.wr & ~bus.wr_bit;
  assign w_wr_sel = w_wr_en & (bus.wr_addr == SFR_SEL);
  assign w_wr_lo  = w_wr_en & (bus.wr_addr == SFR_LO);
  assign w_wr_hi  = w_wr_en & (bus.wr_addr == SFR_HI);
  assign w_wr_ctl = w_wr_en & (bus.wr_addr == SFR_CTL);

  // The select register can hold values past the table end when N_ENTRIES is not a power of two.
  assign w_sel_ok  = (32'(r_sel) < N_ENTRIES);
  assign w_tbl_upd = w_wr_ctl & ~r_lock & w_sel_ok;

  // Valid bit of the currently selected entry, zero when sel is out of range.
  always_comb begin
    w_sel_valid = 1'b0;
    if (w_sel_ok) w_sel_valid = r_valid[r_sel];
  end

  assign w_idx_ok    = ({1'b0, r_idx} < 5'(N_ENTRIES));
  assign w_idx_trunc = r_idx[IDX_W-1:0];

  // Lookup result from the current table state; a faulting lookup returns target 0.
  always_comb begin
    w_lk_fault  = 1'b1;
    w_lk_target = '0;
    if (w_idx_ok && r_valid[w_idx_trunc]) begin
      w_lk_fault  = 1'b0;
      w_lk_target = r_entry[w_idx_trunc];
    end
  end

  // Select and staging registers; these stay writable after lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_stage <= '0;
    end else begin
      if (w_wr_sel) r_sel <= bus.data_in[IDX_W-1:0];
      if (w_wr_lo)  r_stage[7:0] <= bus.data_in;
      if (w_wr_hi)  r_stage[ADDR_W-1:8] <= bus.data_in[HI_W-1:0];
    end
  end

  // Table entries, valid bits and lock. Lock is sampled pre-edge, so LOCK|COMMIT still commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) r_entry[i] <= '0;
      r_valid <= '0;
      r_lock  <= 1'b0;
    end else begin
      if (w_tbl_upd) begin
        if (bus.data_in[1]) begin
          r_valid[r_sel] <= 1'b0;
        end else if (bus.data_in[0]) begin
          r_entry[r_sel] <= r_stage;
          r_valid[r_sel] <= 1'b1;
        end
      end
      if (w_wr_ctl && bus.data_in[7]) r_lock <= 1'b1;
    end
  end

  // Lookup FSM; the result is taken from pre-edge table state when leaving LOOKUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_target <= '0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.ecall_req) begin
            r_idx   <= bus.ecall_idx;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_target <= w_lk_target;
          r_fault  <= w_lk_fault;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational SFR readback.
  always_comb begin
    w_data_out = 8'h00;
    case (bus.rd_addr)
      SFR_SEL: w_data_out[IDX_W-1:0] = r_sel;
      SFR_LO:  w_data_out = r_stage[7:0];
      SFR_HI:  w_data_out[HI_W-1:0] = r_stage[ADDR_W-1:8];
      SFR_CTL: w_data_out = {r_lock, 5'b0, w_sel_valid, 1'b0};
      default: w_data_out = 8'h00;
    endcase
  end

  assign bus.data_out     = w_data_out;
  assign bus.ecall_ack    = (r_state == ST_RESP);
  assign bus.ecall_target = r_target;
  assign bus.ecall_fault  = r_fault;
  assign bus.locked       = r_lock;

endmodule
